// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: opcodes, FSM states, ALUOp codes.
// Also used by ALU control; control bundle and per-state decode live here.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LDI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_PASS  = 3'b001;
  localparam logic [2:0] ALU_LDI   = 3'b011;
  localparam logic [2:0] ALU_BEQ   = 3'b100;
  localparam logic [2:0] ALU_BNE   = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_LDI,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_WB_ALU,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       halted;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{aluop: ALU_PASS, default: '0};

  function automatic logic is_known(logic [5:0] op);
    return op inside {OP_R, OP_J, OP_BEQ, OP_BNE,
                      OP_LDI, OP_LW, OP_SW, OP_HALT};
  endfunction

  // Registered part of the Moore outputs for a state.
  function automatic ctrl_t state_outs(state_t s, logic [5:0] op);
    ctrl_t c;
    c = CTRL_RST;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_ONE;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.aluop     = ALU_FUNCT;
      end
      S_EXEC_LDI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.aluop     = ALU_LDI;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (op == OP_R);
      end
      S_MEM_ADDR: c.alu_src_a = 1'b1;
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_BRANCH;
        c.aluop         = (op == OP_BNE) ? ALU_BNE : ALU_BEQ;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_JUMP;
      end
      S_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_fsm.sv
// Multi-cycle MIPS control FSM: state register, next-state and output decode.
// Outputs are registered from the next state; only fetch strobes and illegal follow inputs.
module control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic [2:0] ALUOp,
  output logic       halted,
  output logic       illegal
);

  state_t     state;
  state_t     nxt;
  logic       run;
  logic [5:0] op_q;
  logic [5:0] op_eff;
  ctrl_t      ctl;
  logic       fetch_done;

  assign op_eff = (state == S_DECODE) ? opcode : op_q;

  always_comb begin
    nxt = state;
    if (!run) begin
      nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) nxt = S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            (opcode == OP_R):    nxt = S_EXEC_R;
            (opcode == OP_LDI):  nxt = S_EXEC_LDI;
            (opcode == OP_LW ||
             opcode == OP_SW):   nxt = S_MEM_ADDR;
            (opcode == OP_BEQ ||
             opcode == OP_BNE):  nxt = S_BRANCH;
            (opcode == OP_J):    nxt = S_JUMP;
            (opcode == OP_HALT): nxt = S_HALT;
            default:             nxt = S_FETCH;
          endcase
        end
        S_EXEC_R,
        S_EXEC_LDI: nxt = S_WB_ALU;
        S_MEM_ADDR: nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) nxt = S_MEM_WB;
        S_MEM_WR:   if (mem_ready) nxt = S_FETCH;
        S_HALT:     nxt = S_HALT;
        default:    nxt = S_FETCH;
      endcase
    end
  end

  // run holds off the first fetch until one clean edge after reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      run   <= 1'b0;
      state <= S_FETCH;
      op_q  <= '0;
      ctl   <= CTRL_RST;
    end else begin
      run   <= 1'b1;
      state <= nxt;
      ctl   <= state_outs(nxt, op_eff);
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  assign fetch_done    = run & (state == S_FETCH) & mem_ready;
  assign ir_write      = fetch_done;
  assign pc_write      = ctl.pc_write | fetch_done;
  assign pc_write_cond = ctl.pc_write_cond;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign iord          = ctl.iord;
  assign reg_write     = ctl.reg_write;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign alu_src_a     = ctl.alu_src_a;
  assign pc_source     = ctl.pc_source;
  assign alu_src_b     = ctl.alu_src_b;
  assign ALUOp         = ctl.aluop;
  assign halted        = ctl.halted;
  assign illegal       = (state == S_DECODE) & ~is_known(opcode);

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction phase plans checked every cycle.
// Random opcodes, memory waits and post-decode opcode noise.
module tb_control_fsm;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_write_cond, mem_read, mem_write;
  logic       iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] ALUOp;
  logic       halted, illegal;

  int total = 0;
  int bad   = 0;

  localparam int P_RST  = 0;
  localparam int P_FET  = 1;
  localparam int P_DEC  = 2;
  localparam int P_EXR  = 3;
  localparam int P_EXL  = 4;
  localparam int P_WBA  = 5;
  localparam int P_ADR  = 6;
  localparam int P_RD   = 7;
  localparam int P_MWB  = 8;
  localparam int P_WR   = 9;
  localparam int P_BR   = 10;
  localparam int P_JMP  = 11;
  localparam int P_HLT  = 12;

  logic [5:0] legal [8] = '{6'h00, 6'h02, 6'h04, 6'h05,
                            6'h0F, 6'h23, 6'h2B, 6'h3F};

  always #5 clock = ~clock;

  control_fsm dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode),
    .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .pc_source(pc_source), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .halted(halted), .illegal(illegal)
  );

  logic [18:0] obs;
  assign obs = {ir_write, pc_write, pc_write_cond, mem_read,
                mem_write, iord, reg_write, reg_dst, mem_to_reg,
                alu_src_a, pc_source, alu_src_b, ALUOp,
                halted, illegal};

  function automatic logic is_legal(logic [5:0] op);
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [18:0] ev(int ph, logic [5:0] op,
                                     logic rdy);
    logic ir, pcw, pcwc, mr, mw, io, rw, rd, m2r, asa, hl, il;
    logic [1:0] pcs, asb;
    logic [2:0] ao;
    {ir, pcw, pcwc, mr, mw, io, rw, rd, m2r, asa, hl, il} = '0;
    pcs = 2'b00;
    asb = 2'b00;
    ao  = 3'b001;
    case (ph)
      P_FET: begin
        mr = 1'b1; asb = 2'b01; ir = rdy; pcw = rdy;
      end
      P_DEC: il = !is_legal(op);
      P_EXR: begin asa = 1'b1; ao = 3'b000; end
      P_EXL: begin asa = 1'b1; asb = 2'b10; ao = 3'b011; end
      P_WBA: begin rw = 1'b1; rd = (op == 6'h00); end
      P_ADR: asa = 1'b1;
      P_RD:  begin mr = 1'b1; io = 1'b1; end
      P_MWB: begin rw = 1'b1; m2r = 1'b1; end
      P_WR:  begin mw = 1'b1; io = 1'b1; end
      P_BR: begin
        asa = 1'b1; pcwc = 1'b1; pcs = 2'b01;
        ao = (op == 6'h05) ? 3'b101 : 3'b100;
      end
      P_JMP: begin pcw = 1'b1; pcs = 2'b10; end
      P_HLT: hl = 1'b1;
      default: ;
    endcase
    return {ir, pcw, pcwc, mr, mw, io, rw, rd, m2r, asa,
            pcs, asb, ao, hl, il};
  endfunction

  task automatic step(input int ph, input logic [5:0] op,
                      input logic rdy, input string tag);
    logic [18:0] e;
    mem_ready = rdy;
    e = ev(ph, op, rdy);
    @(negedge clock);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s op=%h got=%b want=%b", tag, op, obs, e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_phase(input int ph, input logic [5:0] op,
                            input int w, input string tag);
    int n;
    logic r;
    n = 0;
    do begin
      if (w >= 0) r = (n >= w);
      else r = (n >= 3) || ($urandom_range(0, 2) != 0);
      step(ph, op, r, tag);
      n++;
    end while (!r);
  endtask

  task automatic noise;
    opcode = 6'($urandom_range(0, 63));
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1;
    repeat (n) step(P_RST, 6'h00, 1'($urandom_range(0, 1)), "rst_hold");
    reset_n = 1'b1;
    step(P_RST, 6'h00, 1'b1, "rst_release");
  endtask

  task automatic instr(input logic [5:0] op, input int w);
    int plan [$];
    opcode = op;
    wait_phase(P_FET, op, w, "fetch");
    step(P_DEC, op, 1'($urandom_range(0, 1)), "decode");
    noise();
    case (op)
      6'h00: plan = '{P_EXR, P_WBA};
      6'h0F: plan = '{P_EXL, P_WBA};
      6'h23: plan = '{P_ADR, P_RD, P_MWB};
      6'h2B: plan = '{P_ADR, P_WR};
      6'h04, 6'h05: plan = '{P_BR};
      6'h02: plan = '{P_JMP};
      6'h3F: for (int i = 0; i < 20; i++) plan.push_back(P_HLT);
      default: plan = {};
    endcase
    foreach (plan[i]) begin
      if (plan[i] == P_RD || plan[i] == P_WR)
        wait_phase(plan[i], op, w, "mem_wait");
      else
        step(plan[i], op, 1'($urandom_range(0, 1)), "exec");
      if (plan[i] == P_HLT) noise();
    end
  endtask

  initial begin
    logic [5:0] op;
    reset_n   = 1'b0;
    opcode    = 6'h00;
    mem_ready = 1'b0;
    do_reset(2);

    instr(6'h00, 0);
    instr(6'h23, 2);
    instr(6'h05, 0);
    instr(6'h3E, 0);
    instr(6'h0F, 0);
    instr(6'h2B, 0);
    instr(6'h04, 1);
    instr(6'h02, 0);

    opcode = 6'h2B;
    step(P_FET, 6'h2B, 1'b1, "sw_fetch");
    step(P_DEC, 6'h2B, 1'b1, "sw_decode");
    step(P_ADR, 6'h2B, 1'b0, "sw_addr");
    step(P_WR, 6'h2B, 1'b0, "sw_wait");
    step(P_WR, 6'h2B, 1'b0, "sw_wait");
    do_reset(1);
    instr(6'h00, 0);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 6)];
      end
      instr(op, -1);
    end

    instr(6'h3F, -1);
    do_reset(1);
    instr(6'h23, 0);
    instr(6'h3F, 0);
    do_reset(1);
    instr(6'h05, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
